// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side and register-file-side signals of the writeback arbiter.
// The arbiter connects through the slave modport; the requesters and register file use master.
interface regfile_wr_arbiter_if #(
    parameter int unsigned DSIZE = 16,
    parameter int unsigned ASIZE = 4,
    parameter int unsigned CSIZE = 16
);
    logic [2:0]       req;
    logic [ASIZE-1:0] waddr0;
    logic [ASIZE-1:0] waddr1;
    logic [ASIZE-1:0] waddr2;
    logic [DSIZE-1:0] wdata0;
    logic [DSIZE-1:0] wdata1;
    logic [DSIZE-1:0] wdata2;
    logic [2:0]       gnt;
    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    logic [CSIZE-1:0] conflicts;

    modport master (
        output req, waddr0, waddr1, waddr2, wdata0, wdata1, wdata2,
        input  gnt, wen, waddr, wdata, conflicts
    );

    modport slave (
        input  req, waddr0, waddr1, waddr2, wdata0, wdata1, wdata2,
        output gnt, wen, waddr, wdata, conflicts
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among three writeback sources.
// Grant is combinational; the winning write is registered and presented the following cycle.
module regfile_wr_arbiter #(
    parameter int unsigned DSIZE = 16,
    parameter int unsigned ASIZE = 4,
    parameter int unsigned CSIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wr_arbiter_if.slave bus
);
    logic [1:0]       last_q, last_d;
    logic [2:0]       gnt_d;
    logic             wen_q, wen_d;
    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;
    logic [CSIZE-1:0] conf_q, conf_d;
    logic [ASIZE-1:0] sel_addr;
    logic [DSIZE-1:0] sel_data;
    logic             multi_req;

    // Search starts one past the last winner and wraps; no grant while in reset.
    always_comb begin
        gnt_d = '0;
        if (!rst) begin
            case (last_q)
                2'd0: begin
                    if      (bus.req[1]) gnt_d = 3'b010;
                    else if (bus.req[2]) gnt_d = 3'b100;
                    else if (bus.req[0]) gnt_d = 3'b001;
                end
                2'd1: begin
                    if      (bus.req[2]) gnt_d = 3'b100;
                    else if (bus.req[0]) gnt_d = 3'b001;
                    else if (bus.req[1]) gnt_d = 3'b010;
                end
                default: begin
                    if      (bus.req[0]) gnt_d = 3'b001;
                    else if (bus.req[1]) gnt_d = 3'b010;
                    else if (bus.req[2]) gnt_d = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        sel_addr = bus.waddr2;
        sel_data = bus.wdata2;
        if (gnt_d[0]) begin
            sel_addr = bus.waddr0;
            sel_data = bus.wdata0;
        end else if (gnt_d[1]) begin
            sel_addr = bus.waddr1;
            sel_data = bus.wdata1;
        end
    end

    assign multi_req = (bus.req[0] & bus.req[1]) | (bus.req[0] & bus.req[2]) |
                       (bus.req[1] & bus.req[2]);

    always_comb begin
        last_d  = last_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        conf_d  = conf_q;
        if (gnt_d != '0) begin
            // R0 writes are granted and latched but never enabled.
            wen_d   = (sel_addr != '0);
            waddr_d = sel_addr;
            wdata_d = sel_data;
            last_d  = gnt_d[0] ? 2'd0 : (gnt_d[1] ? 2'd1 : 2'd2);
        end
        if (multi_req && (conf_q != '1)) begin
            conf_d = conf_q + CSIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 2'd2;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            conf_q  <= '0;
        end else begin
            last_q  <= last_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            conf_q  <= conf_d;
        end
    end

    assign bus.gnt       = gnt_d;
    assign bus.wen       = wen_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.conflicts = conf_q;
endmodule
